// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-controlled ALU command sequencer.
//   - ALU opcode encodings carried in the low three bits of the header byte
//   - header tag expected in header bits [7:3]
//   - sequencer state encoding
//   - STATUS response byte bit positions and helpers to build/check bytes
package uart_alu_pkg;

    // ALU opcodes (header bits [2:0], passed straight through to alu_sel)
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;
    localparam logic [2:0] ALU_INC  = 3'd6;
    localparam logic [2:0] ALU_DEC  = 3'd7;

    // Header tag occupying bits [7:3] of a valid header byte
    localparam logic [4:0] HDR_TAG = 5'b10100;

    // STATUS byte bit positions
    localparam int ST_ZERO = 0;
    localparam int ST_OVR  = 1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_GET_AH  = 4'd1,
        S_GET_AL  = 4'd2,
        S_GET_BH  = 4'd3,
        S_GET_BL  = 4'd4,
        S_EXEC    = 4'd5,
        S_SEND_RH = 4'd6,
        S_WAIT_RH = 4'd7,
        S_SEND_RL = 4'd8,
        S_WAIT_RL = 4'd9,
        S_SEND_ST = 4'd10,
        S_WAIT_ST = 4'd11
    } state_t;

    // True when the byte carries the command header tag
    function automatic logic hdr_valid(input logic [7:0] b);
        return (b[7:3] == HDR_TAG);
    endfunction

    // Assemble the STATUS response byte; upper bits are always zero
    function automatic logic [7:0] status_byte(input logic zero, input logic ovr);
        logic [7:0] s;
        s          = 8'h00;
        s[ST_ZERO] = zero;
        s[ST_OVR]  = ovr;
        return s;
    endfunction

endpackage

// File: rtl/uart_alu_cmd_ctrl_byte_timeout.sv
// Inter-byte timeout counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : return the count to zero (has priority over counting)
//   en       : count one cycle of waiting
//   expire   : one-cycle flag, high while enabled, not cleared, and the
//              count has reached TIMEOUT_CYCLES-1
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Wait counter: cleared on request, saturates at the expiry value
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A clear in the same cycle (an accepted byte) cancels expiry
    assign expire = en & ~clr & (cnt_r == CNT_MAX);

endmodule

// File: rtl/uart_alu_cmd_ctrl.sv
// Command sequencer between the UART and a combinational ALU.
// Collects a 5-byte frame (HDR, A_HI, A_LO, B_HI, B_LO), drives the ALU
// operands/opcode, captures RESULT/ZERO, and returns RES_HI, RES_LO, STATUS
// through the TX start/busy handshake.
//   clk, rst              : clock, synchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   tx_data, tx_start     : byte to send and one-cycle transmit request
//   tx_busy               : transmitter busy
//   alu_a, alu_b, alu_sel : registered ALU operands and opcode
//   alu_result, alu_zero  : ALU outputs
//   busy                  : sequencer not idle
//   hdr_err, frame_err    : one-cycle error pulses (bad header / timeout)
module uart_alu_cmd_ctrl
    import uart_alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        busy,
    output logic        hdr_err,
    output logic        frame_err
);

    state_t      state_r, state_s;
    logic        in_get_s, hdr_ok_s, accept_hdr_s, drop_s;
    logic        tout_clr_s, expire_s, tx_start_s;
    logic [15:0] alu_a_r, alu_a_s, alu_b_r, alu_b_s, result_r, result_s;
    logic [2:0]  alu_sel_r, alu_sel_s;
    logic        zero_r, zero_s, ovr_r, ovr_s;
    logic [7:0]  tx_data_r, tx_data_s;
    logic        busy_r, hdr_err_r, hdr_err_s, frame_err_r, frame_err_s;

    assign in_get_s     = (state_r == S_GET_AH) || (state_r == S_GET_AL) ||
                          (state_r == S_GET_BH) || (state_r == S_GET_BL);
    assign hdr_ok_s     = hdr_valid(rx_data);
    assign accept_hdr_s = (state_r == S_IDLE) && rx_valid && hdr_ok_s;
    // Bytes arriving while executing or responding are dropped
    assign drop_s       = rx_valid && (state_r != S_IDLE) && !in_get_s;
    // Counter idles at zero outside GET_*, so entering GET_* starts from zero
    assign tout_clr_s   = !in_get_s || rx_valid;

    byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_byte_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tout_clr_s),
        .en     (in_get_s),
        .expire (expire_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_hdr_s) state_s = S_GET_AH;
                else              state_s = S_IDLE;
            end
            S_GET_AH: begin
                if (rx_valid)      state_s = S_GET_AL;
                else if (expire_s) state_s = S_IDLE;
                else               state_s = S_GET_AH;
            end
            S_GET_AL: begin
                if (rx_valid)      state_s = S_GET_BH;
                else if (expire_s) state_s = S_IDLE;
                else               state_s = S_GET_AL;
            end
            S_GET_BH: begin
                if (rx_valid)      state_s = S_GET_BL;
                else if (expire_s) state_s = S_IDLE;
                else               state_s = S_GET_BH;
            end
            S_GET_BL: begin
                if (rx_valid)      state_s = S_EXEC;
                else if (expire_s) state_s = S_IDLE;
                else               state_s = S_GET_BL;
            end
            S_EXEC: state_s = S_SEND_RH;
            S_SEND_RH: begin
                if (!tx_busy) state_s = S_WAIT_RH;
                else          state_s = S_SEND_RH;
            end
            S_WAIT_RH: begin
                if (!tx_busy) state_s = S_SEND_RL;
                else          state_s = S_WAIT_RH;
            end
            S_SEND_RL: begin
                if (!tx_busy) state_s = S_WAIT_RL;
                else          state_s = S_SEND_RL;
            end
            S_WAIT_RL: begin
                if (!tx_busy) state_s = S_SEND_ST;
                else          state_s = S_WAIT_RL;
            end
            S_SEND_ST: begin
                if (!tx_busy) state_s = S_WAIT_ST;
                else          state_s = S_SEND_ST;
            end
            S_WAIT_ST: begin
                if (!tx_busy) state_s = S_IDLE;
                else          state_s = S_WAIT_ST;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode: tx_start must see tx_busy in the same cycle, so it is
    // decoded from the state register rather than registered again
    always_comb begin
        tx_start_s = 1'b0;
        case (state_r)
            S_SEND_RH, S_SEND_RL, S_SEND_ST: tx_start_s = !tx_busy;
            default:                         tx_start_s = 1'b0;
        endcase
    end

    // Datapath next values: operand assembly, result capture, TX byte staging
    always_comb begin
        alu_a_s     = alu_a_r;
        alu_b_s     = alu_b_r;
        alu_sel_s   = alu_sel_r;
        result_s    = result_r;
        zero_s      = zero_r;
        tx_data_s   = tx_data_r;
        hdr_err_s   = (state_r == S_IDLE) && rx_valid && !hdr_ok_s;
        frame_err_s = in_get_s && expire_s;

        if (accept_hdr_s) begin
            ovr_s = 1'b0;
        end else if (drop_s) begin
            ovr_s = 1'b1;
        end else begin
            ovr_s = ovr_r;
        end

        case (state_r)
            S_IDLE: begin
                if (accept_hdr_s) alu_sel_s = rx_data[2:0];
                else              alu_sel_s = alu_sel_r;
            end
            S_GET_AH: begin
                if (rx_valid) alu_a_s[15:8] = rx_data;
                else          alu_a_s       = alu_a_r;
            end
            S_GET_AL: begin
                if (rx_valid) alu_a_s[7:0] = rx_data;
                else          alu_a_s      = alu_a_r;
            end
            S_GET_BH: begin
                if (rx_valid) alu_b_s[15:8] = rx_data;
                else          alu_b_s       = alu_b_r;
            end
            S_GET_BL: begin
                if (rx_valid) alu_b_s[7:0] = rx_data;
                else          alu_b_s      = alu_b_r;
            end
            S_EXEC: begin
                result_s  = alu_result;
                zero_s    = alu_zero;
                tx_data_s = alu_result[15:8];
            end
            S_WAIT_RH: begin
                if (!tx_busy) tx_data_s = result_r[7:0];
                else          tx_data_s = tx_data_r;
            end
            S_WAIT_RL: begin
                if (!tx_busy) tx_data_s = status_byte(zero_r, ovr_s);
                else          tx_data_s = tx_data_r;
            end
            S_SEND_ST: begin
                // Still waiting to issue: keep STATUS current with late overruns
                if (tx_busy) tx_data_s = status_byte(zero_r, ovr_s);
                else         tx_data_s = tx_data_r;
            end
            default: tx_data_s = tx_data_r;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r     <= 16'h0000;
            alu_b_r     <= 16'h0000;
            alu_sel_r   <= 3'd0;
            result_r    <= 16'h0000;
            zero_r      <= 1'b0;
            ovr_r       <= 1'b0;
            tx_data_r   <= 8'h00;
            busy_r      <= 1'b0;
            hdr_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            alu_a_r     <= alu_a_s;
            alu_b_r     <= alu_b_s;
            alu_sel_r   <= alu_sel_s;
            result_r    <= result_s;
            zero_r      <= zero_s;
            ovr_r       <= ovr_s;
            tx_data_r   <= tx_data_s;
            busy_r      <= (state_s != S_IDLE);
            hdr_err_r   <= hdr_err_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign tx_data   = tx_data_r;
    assign tx_start  = tx_start_s;
    assign busy      = busy_r;
    assign hdr_err   = hdr_err_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
module tb_uart_alu_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        busy, hdr_err, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int he_cnt = 0;
    int fe_cnt = 0;
    int last_rx_cyc = 0;
    int busy_len = 1;
    int busy_cnt = 0;
    logic [7:0] exp_q[$];
    int tx_cyc_log[$];

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  rh;
        logic [7:0]  rl;
        logic [7:0]  st;
    } vec_t;
    vec_t tbl[9];

    uart_alu_cmd_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .hdr_err(hdr_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU model
    logic [15:0] r_s;
    always_comb begin
        case (alu_sel)
            3'd0: r_s = alu_a + alu_b;
            3'd1: r_s = alu_a - alu_b;
            3'd2: r_s = alu_a & alu_b;
            3'd3: r_s = alu_a | alu_b;
            3'd4: r_s = alu_a ^ alu_b;
            3'd5: r_s = alu_a;
            3'd6: r_s = alu_a + 16'd1;
            3'd7: r_s = alu_a - 16'd1;
            default: r_s = 16'h0000;
        endcase
    end
    assign alu_result = r_s;
    assign alu_zero   = (r_s == 16'h0000);

    // UART TX model: busy from the cycle after a start, for busy_len cycles
    always @(posedge clk) begin
        if (tx_start && busy_cnt == 0) busy_cnt <= busy_len;
        else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every tx_start pops one expected byte
    always @(negedge clk) begin
        if (!rst) begin
            if (hdr_err)   he_cnt++;
            if (frame_err) fe_cnt++;
            if (tx_start) begin
                tx_cnt++;
                tx_cyc_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: actual=%0h required=none (t=%0t)", tx_data, $time);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                chk("tx_idle_at_start", 32'(tx_busy), 32'd0);
            end
        end
    end

    // Called at a negedge; holds rx_valid across exactly one rising edge
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("response_done_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("tx_seen_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic run_frame(input vec_t v, input bit chk_lat);
        int base;
        base = tx_cyc_log.size();
        exp_q.push_back(v.rh);
        exp_q.push_back(v.rl);
        exp_q.push_back(v.st);
        send_byte(v.hdr);
        send_byte(v.a[15:8]);
        send_byte(v.a[7:0]);
        send_byte(v.b[15:8]);
        send_byte(v.b[7:0]);
        wait_done(500);
        if (chk_lat) begin
            if (tx_cyc_log.size() > base)
                chk("latency", 32'(tx_cyc_log[base] - last_rx_cyc), 32'd2);
            else
                chk("latency_no_tx", 32'd0, 32'd1);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hdr_err", 32'(hdr_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int early;
        int base;

        tbl[0] = '{8'hA0, 16'h1234, 16'h0001, 8'h12, 8'h35, 8'h00}; // add
        tbl[1] = '{8'hA1, 16'h0005, 16'h0005, 8'h00, 8'h00, 8'h01}; // sub -> zero
        tbl[2] = '{8'hA7, 16'h0000, 16'hABCD, 8'hFF, 8'hFF, 8'h00}; // dec wrap
        tbl[3] = '{8'hA2, 16'hF0F0, 16'h0FFF, 8'h00, 8'hF0, 8'h00}; // and
        tbl[4] = '{8'hA3, 16'h1200, 16'h0034, 8'h12, 8'h34, 8'h00}; // or
        tbl[5] = '{8'hA4, 16'hFF00, 16'h0F0F, 8'hF0, 8'h0F, 8'h00}; // xor
        tbl[6] = '{8'hA5, 16'hBEEF, 16'h1111, 8'hBE, 8'hEF, 8'h00}; // pass A
        tbl[7] = '{8'hA6, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 8'h01}; // inc wrap
        tbl[8] = '{8'hA1, 16'h0000, 16'h0001, 8'hFF, 8'hFF, 8'h00}; // sub wrap

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        // Table-driven frames with an idle, fast transmitter
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                send_byte(8'h55);
                chk("hdr_err_pulse", 32'(hdr_err), 32'd1);
                chk("hdr_busy", 32'(busy), 32'd0);
                @(negedge clk);
                chk("hdr_err_single", 32'(hdr_err), 32'd0);
                chk("hdr_busy_after", 32'(busy), 32'd0);
            end
            run_frame(tbl[i], 1'b1);
            if (i == 0) begin
                chk("alu_a_loaded", 32'(alu_a), 32'h1234);
                chk("alu_b_loaded", 32'(alu_b), 32'h0001);
            end
        end
        chk("operands_hold_in_idle", 32'(alu_b), 32'h0001);

        // Timeout: header and one byte, then silence
        send_byte(8'hA3);
        send_byte(8'h12);
        early = 0;
        for (int i = 0; i < 16; i++) begin
            if (frame_err) early++;
            @(negedge clk);
        end
        chk("no_early_frame_err", 32'(early), 32'd0);
        chk("frame_err_pulse", 32'(frame_err), 32'd1);
        chk("timeout_idle", 32'(busy), 32'd0);
        chk("partial_a_hi_kept", 32'(alu_a[15:8]), 32'h12);
        @(negedge clk);
        chk("frame_err_single", 32'(frame_err), 32'd0);

        // Byte arriving in the expiry cycle is accepted
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h35);
        exp_q.push_back(8'h00);
        send_byte(8'hA3);
        send_byte(8'h12);
        repeat (15) @(negedge clk);
        send_byte(8'h34);
        chk("late_byte_no_err", 32'(frame_err), 32'd0);
        chk("late_byte_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h05);
        wait_done(500);

        // Slow transmitter plus a byte injected while waiting on RES_HI
        busy_len = 50;
        base = tx_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h02);
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        wait_tx(base + 1, 200);
        repeat (3) @(negedge clk);
        send_byte(8'h77);
        wait_done(1000);
        chk("stall_tx_count", 32'(tx_cnt - base), 32'd3);

        // Next header clears the overrun flag
        busy_len = 1;
        repeat (60) @(negedge clk);
        v = '{8'hA0, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h01};
        run_frame(v, 1'b1);

        // Reset while waiting on RES_LO
        busy_len = 50;
        base = tx_cnt;
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'h00);
        send_byte(8'hA5);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h11);
        send_byte(8'h11);
        wait_tx(base + 2, 400);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs();
        chk("rst_pending_bytes", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        base = tx_cnt;
        repeat (120) @(negedge clk);
        chk("no_tx_after_rst", 32'(tx_cnt - base), 32'd0);

        busy_len = 1;
        v = '{8'hA4, 16'hFF00, 16'h0F0F, 8'hF0, 8'h0F, 8'h00};
        run_frame(v, 1'b1);

        chk("hdr_err_count", 32'(he_cnt), 32'd1);
        chk("frame_err_count", 32'(fe_cnt), 32'd1);
        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_alu_cmd_ctrl.md
Name: uart_alu_cmd_ctrl

Overview:
Command sequencer between the UART receiver/transmitter and the combinational ALU. It assembles a 5-byte command frame from RX bytes, drives the ALU operand and select lines, and captures RESULT and ZERO. It then returns a 3-byte response through the UART TX handshake. It owns framing, the inter-byte timeout and error flags for the UART-controlled ALU.

Parameters:
TIMEOUT_CYCLES, 100000, max idle clk cycles between bytes of one frame before abort (>=2)
CNT_W, 17, width of timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit, held stable while tx_start high
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  TX busy; TX raises it the cycle after accepting tx_start, lowers it when the byte is done
alu_a  out  16  operand A to ALU
alu_b  out  16  operand B to ALU
alu_sel  out  3  ALU opcode
alu_result  in  16  ALU RESULT
alu_zero  in  1  ALU ZERO
busy  out  1  high whenever state != IDLE
hdr_err  out  1  one-cycle pulse: invalid header byte dropped
frame_err  out  1  one-cycle pulse: frame aborted on timeout

Behaviour:
- Reset: state IDLE. alu_a, alu_b, alu_sel, tx_data, captured result and status are 0. tx_start, busy, hdr_err, frame_err and the overrun flag are 0.
- Frame, in order: HDR, A_HI, A_LO, B_HI, B_LO.
- A valid HDR has HDR[7:3]==5'b10100. HDR[2:0] gives alu_sel: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 pass A, 110 inc A, 111 dec A.
- Response, in order: RES_HI, RES_LO, STATUS. STATUS[0]=zero, STATUS[1]=overrun, STATUS[7:2]=0.
- States: IDLE, GET_AH, GET_AL, GET_BH, GET_BL, EXEC, SEND_RH, WAIT_RH, SEND_RL, WAIT_RL, SEND_ST, WAIT_ST.
- IDLE, rx_valid with valid HDR: load alu_sel, clear overrun, go to GET_AH.
- IDLE, rx_valid with invalid HDR: pulse hdr_err next cycle, stay in IDLE, no TX.
- GET_*: each rx_valid writes the matching byte of alu_a or alu_b and advances the state. GET_BL goes to EXEC.
- Timeout counter clears on entry to any GET_* state and on every accepted byte.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 with no rx_valid, pulse frame_err and go to IDLE. Operands keep their partial values; no TX.
- rx_valid in the timeout-expiry cycle: the byte is accepted and there is no timeout.
- EXEC, one cycle: alu_a, alu_b and alu_sel are already registered and stable. Capture alu_result and alu_zero at the end of this cycle.
- Latency: B_LO rx_valid in cycle t, EXEC in t+1, tx_start high in t+2 with tx_data=RES_HI, if tx_busy=0.
- SEND_x: drive tx_data. Assert tx_start for exactly one cycle, only when tx_busy=0; otherwise hold in SEND_x. Then go to WAIT_x.
- WAIT_x: remain until tx_busy=0, then go to the next SEND state. WAIT_ST goes to IDLE.
- tx_data holds its value from SEND through WAIT.
- rx_valid in EXEC, SEND_* or WAIT_*: byte dropped, overrun flag set. The flag is reported in this transaction's STATUS only if set before SEND_ST issues.
- Result arithmetic is the ALU's own 16-bit mod-2^16 wrap; no carry is reported.
- alu_a, alu_b and alu_sel remain unchanged in IDLE after a transaction, until the next frame loads them.
- rst mid-frame or mid-transmit: back to the reset state on the next edge. Any tx_start in flight is deasserted, and the remaining response bytes are never sent.

Decomposition:
- Package uart_alu_pkg holds: ALU_SEL opcode localparams (ADD..DEC), HDR_TAG=5'b10100, state enum typedef, and STATUS bit indices (ST_ZERO=0, ST_OVR=1).
- One sub-module, byte_timeout: a counter with clear/enable inputs, a one-cycle expire output, and parameters TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Frame A0 12 34 00 01 with TX ready -> alu_a=0x1234, alu_b=0x0001; TX bytes 12, 35, 00; tx_start exactly 2 cycles after the last rx_valid.
- Frame A1 00 05 00 05 (sub) -> TX 00, 00, 01 (zero set); Frame A7 00 00 xx xx (dec) -> TX FF, FF, 00 (wrap).
- Header 0x55 -> hdr_err single pulse, busy stays 0, no tx_start. Then frame A2 F0 F0 0F FF -> TX 00, F0, 00.
- Send A3 12 then idle TIMEOUT_CYCLES (set to 16) -> frame_err pulse after 16 idle cycles, IDLE, no TX. A byte in cycle 16 instead -> accepted, no error.
- Hold tx_busy high for 50 cycles per byte; inject an rx byte during WAIT_RH -> tx_start never asserted while busy, each byte exactly once, STATUS=0x02 (or 0x03 if result is zero).
- Assert rst in WAIT_RL -> next cycle outputs at reset values, no further tx_start. A following frame A4 FF 00 0F 0F (xor) -> TX F0, 0F, 00.
